// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shift-type codes, FSM state type and a legality helper
// shared by the iterative shifter and its single-step datapath.
package iter_shifter_pkg;

    localparam logic [2:0] SH_ROTL = 3'd0;
    localparam logic [2:0] SH_ROTR = 3'd1;
    localparam logic [2:0] SH_SHL  = 3'd2;
    localparam logic [2:0] SH_ASR  = 3'd3;
    localparam logic [2:0] SH_LSR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codes above SH_LSR are reserved and flagged as errors.
    function automatic logic sh_legal(input logic [2:0] t);
        return (t <= SH_LSR);
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: start/done request bus between the control FSM (master)
// and the iterative shifter (slave).
interface iter_shifter_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] data;
    logic [2:0]       sh_type;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, flush, data, sh_type, amount,
        input  out, carry, zero, err, busy, done
    );

    modport slave (
        input  start, flush, data, sh_type, amount,
        output out, carry, zero, err, busy, done
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// shift_step: one-bit rotate/shift of the working word, plus the bit that
// leaves the word. Reserved type codes pass the word through unchanged.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_w,
    input  logic [2:0]       i_type,
    output logic [WIDTH-1:0] o_w_next,
    output logic             o_bit_out
);

    // Select the single-position operation for the captured type.
    always_comb begin
        o_w_next  = i_w;
        o_bit_out = 1'b0;
        case (i_type)
            SH_ROTL: begin
                o_w_next  = {i_w[WIDTH-2:0], i_w[WIDTH-1]};
                o_bit_out = i_w[WIDTH-1];
            end
            SH_ROTR: begin
                o_w_next  = {i_w[0], i_w[WIDTH-1:1]};
                o_bit_out = i_w[0];
            end
            SH_SHL: begin
                o_w_next  = {i_w[WIDTH-2:0], 1'b0};
                o_bit_out = i_w[WIDTH-1];
            end
            SH_ASR: begin
                o_w_next  = {i_w[WIDTH-1], i_w[WIDTH-1:1]};
                o_bit_out = i_w[0];
            end
            SH_LSR: begin
                o_w_next  = {1'b0, i_w[WIDTH-1:1]};
                o_bit_out = i_w[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle rotate/shift unit, one bit position per clock,
// with start/done handshake, synchronous flush and carry/zero/err flags.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_shifter_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_count;
    logic [2:0]       r_type;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic             w_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_w       (r_work),
        .i_type    (r_type),
        .o_w_next  (w_next),
        .o_bit_out (w_bit)
    );

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_count <= '0;
            r_type  <= SH_ROTL;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                // Abort: result flags keep whatever they last held.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            r_work  <= bus.data;
                            r_count <= bus.amount;
                            r_type  <= bus.sh_type;
                            if (!sh_legal(bus.sh_type) || bus.amount == '0) begin
                                r_state <= ST_DONE;
                                r_carry <= 1'b0;
                                r_err   <= !sh_legal(bus.sh_type);
                                r_zero  <= (bus.data == '0);
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_SHIFT;
                                r_err   <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_SHIFT: begin
                        r_work  <= w_next;
                        r_carry <= w_bit;
                        r_count <= r_count - 1'b1;
                        if (r_count == AMT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_zero  <= (w_next == '0);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out   = r_work;
    assign bus.carry = r_carry;
    assign bus.zero  = r_zero;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed scenarios plus randomized traffic, checked every
// cycle against an arithmetic model of the shifter's results and timing.
module tb_iter_shifter;

    localparam int W  = 8;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    iter_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of applying operation t to d, n positions, computed in one go.
    function automatic void ref_op(input logic [W-1:0] d, input int t, input int n,
                                   output logic [W-1:0] r, output logic c);
        int m;
        r = d;
        c = 1'b0;
        if (n == 0 || t > 4) return;
        m = n % W;
        case (t)
            0: begin r = (d << m) | (d >> (W - m)); c = r[0]; end
            1: begin r = (d >> m) | (d << (W - m)); c = r[W-1]; end
            2: begin
                if (n >= W) r = '0; else r = d << n;
                c = (n > W) ? 1'b0 : d[W-n];
            end
            3: begin
                if (n >= W) r = {W{d[W-1]}}; else r = $signed(d) >>> n;
                c = (n > W) ? d[W-1] : d[n-1];
            end
            default: begin
                if (n >= W) r = '0; else r = d >> n;
                c = (n > W) ? 1'b0 : d[n-1];
            end
        endcase
    endfunction

    // Model: timing of the current operation and the values held at rest.
    logic         m_active = 1'b0;
    int           m_el = 0;
    int           m_k = 0;
    logic [W-1:0] m_d = '0;
    int           m_t = 0;
    logic [W-1:0] h_out = '0;
    logic         h_carry = 1'b0;
    logic         h_zero = 1'b0;
    logic         h_err = 1'b0;
    logic         e_busy, e_done;
    logic [W-1:0] mr;
    logic         mc;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out", bus.out, 0);
            chk("rst_carry", bus.carry, 0);
            chk("rst_zero", bus.zero, 0);
            chk("rst_err", bus.err, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            m_active = 1'b0;
            h_out = '0; h_carry = 1'b0; h_zero = 1'b0; h_err = 1'b0;
        end else begin
            e_busy = m_active && (m_el < m_k);
            e_done = m_active && (m_el == m_k);
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            if (!e_busy) begin
                chk("out", bus.out, h_out);
                chk("carry", bus.carry, h_carry);
                chk("zero", bus.zero, h_zero);
                chk("err", bus.err, h_err);
            end
            // Predict the effect of the coming edge from the current inputs.
            if (bus.flush) begin
                if (e_busy) begin
                    if (m_el > 0) begin
                        ref_op(m_d, m_t, m_el, mr, mc);
                        h_out = mr; h_carry = mc;
                    end else begin
                        h_out = m_d;
                    end
                end
                m_active = 1'b0;
            end else if (bus.start && !e_busy) begin
                m_active = 1'b1;
                m_el = 0;
                m_d = bus.data;
                m_t = int'(bus.sh_type);
                if (m_t > 4) begin
                    m_k = 0;
                    h_err = 1'b1;
                end else begin
                    m_k = int'(bus.amount);
                    h_err = 1'b0;
                end
                if (m_k == 0) begin
                    h_out = m_d; h_carry = 1'b0; h_zero = (m_d == '0);
                end
            end else if (m_active) begin
                m_el++;
                if (m_el == m_k) begin
                    ref_op(m_d, m_t, m_k, mr, mc);
                    h_out = mr; h_carry = mc; h_zero = (mr == '0);
                end else if (m_el > m_k) begin
                    m_active = 1'b0;
                end
            end
        end
    end

    // Issue one op at posedge+1 and wait (bounded) for done; checks literals.
    task automatic run_op(input string name, input logic [W-1:0] d, input logic [2:0] t,
                          input logic [AW-1:0] a, input logic [W-1:0] x_out,
                          input logic x_carry, input int x_lat);
        int lat;
        bus.start = 1'b1; bus.data = d; bus.sh_type = t; bus.amount = a;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data = W'($urandom); bus.sh_type = 3'($urandom); bus.amount = AW'($urandom);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end else begin
            chk({name, "_lat"}, lat, x_lat);
            chk({name, "_out"}, bus.out, x_out);
            chk({name, "_carry"}, bus.carry, x_carry);
        end
    endtask

    logic [W-1:0] pr;
    logic         pc;
    int           lat;
    int           seen;

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.data = '0; bus.sh_type = '0; bus.amount = '0;

        ref_op(8'h81, 0, 1, pr, pc);  chk("pin_rotl", {pr, pc}, {8'h03, 1'b1});
        ref_op(8'h90, 3, 3, pr, pc);  chk("pin_asr", {pr, pc}, {8'hF2, 1'b0});
        ref_op(8'hFF, 2, 12, pr, pc); chk("pin_shl12", {pr, pc}, {8'h00, 1'b0});
        ref_op(8'h12, 0, 9, pr, pc);  chk("pin_rotl9", {pr, pc}, {8'h24, 1'b0});
        ref_op(8'h01, 1, 5, pr, pc);  chk("pin_rotr5", {pr, pc}, {8'h08, 1'b0});
        ref_op(8'h80, 3, 10, pr, pc); chk("pin_asr10", {pr, pc}, {8'hFF, 1'b1});
        ref_op(8'h01, 4, 1, pr, pc);  chk("pin_lsr", {pr, pc}, {8'h00, 1'b1});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("rotl81", 8'h81, 3'd0, 4'd1, 8'h03, 1'b1, 2);
        chk("rotl81_zero", bus.zero, 0);
        @(posedge clk); #1;
        run_op("asr90", 8'h90, 3'd3, 4'd3, 8'hF2, 1'b0, 4);
        @(posedge clk); #1;
        run_op("lsr01", 8'h01, 3'd4, 4'd1, 8'h00, 1'b1, 2);
        chk("lsr01_zero", bus.zero, 1);
        run_op("shl01_b2b", 8'h01, 3'd2, 4'd7, 8'h80, 1'b0, 8);
        @(posedge clk); #1;
        run_op("shlFF12", 8'hFF, 3'd2, 4'd12, 8'h00, 1'b0, 13);
        run_op("rotrA5_0", 8'hA5, 3'd1, 4'd0, 8'hA5, 1'b0, 1);
        run_op("rotl12_9", 8'h12, 3'd0, 4'd9, 8'h24, 1'b0, 10);
        @(posedge clk); #1;
        run_op("illegal", 8'h3C, 3'd6, 4'd5, 8'h3C, 1'b0, 1);
        chk("illegal_err", bus.err, 1);
        @(posedge clk); #1;

        // Start pulse during SHIFT must not disturb the running op.
        bus.start = 1'b1; bus.data = 8'h01; bus.sh_type = 3'd1; bus.amount = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.data = 8'hFF; bus.sh_type = 3'd0; bus.amount = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_lat", lat, 6);
        chk("ignore_out", bus.out, 8'h08);
        @(posedge clk); #1;

        // Reset in the middle of a long op.
        bus.start = 1'b1; bus.data = 8'h80; bus.sh_type = 3'd3; bus.amount = 4'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out", bus.out, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush in the middle of the same op: 3 steps done, then abort.
        bus.start = 1'b1; bus.data = 8'h80; bus.sh_type = 3'd3; bus.amount = 4'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        seen = 0;
        repeat (12) begin
            if (bus.done) seen++;
            @(posedge clk); #1;
        end
        chk("flush_nodone", seen, 0);
        chk("flush_out", bus.out, 8'hF0);
        chk("flush_busy", bus.busy, 0);

        // Randomized traffic, including starts during SHIFT and stray flushes.
        for (int i = 0; i < 3000; i++) begin
            bus.start   = ($urandom_range(0, 2) == 0);
            bus.flush   = ($urandom_range(0, 24) == 0);
            bus.data    = W'($urandom);
            bus.sh_type = 3'($urandom);
            bus.amount  = AW'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the datapath's combinational single-bit shifter.
- Performs rotate, logical and arithmetic shifts on a WIDTH-bit operand by a variable amount, one bit position per clock.
- Uses a start/done handshake and reports carry-out, zero and error flags.
- Sits beside the ALU in the multi-cycle CPU; the control FSM issues start and waits on done.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- AMT_W, 4, width of the shift-amount input; maximum amount is 2^AMT_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- flush  input  1  synchronous abort; returns the block to IDLE.
- data  input  WIDTH  operand, captured on an accepted start.
- sh_type  input  3  0 rotl, 1 rotr, 2 shl, 3 asr, 4 lsr, 5-7 illegal.
- amount  input  AMT_W  shift count, captured on an accepted start.
- out  output  WIDTH  registered result.
- carry  output  1  last bit shifted/rotated out.
- zero  output  1  out == 0 at completion.
- err  output  1  illegal sh_type on the last operation.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - out, carry, zero, err, busy, done all 0; internal count 0.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Capture data into the working register and amount into count.
  - If sh_type > 4: go to DONE; out = data, carry 0, err 1.
  - Else if amount == 0: go to DONE; out = data, carry 0, err 0.
  - Else: go to SHIFT with err 0.
- SHIFT, each cycle:
  - Apply one 1-bit operation of the captured type:
    - rotl: {w[W-2:0], w[W-1]}, carry = w[W-1].
    - rotr: {w[0], w[W-1:1]}, carry = w[0].
    - shl: {w[W-2:0], 0}, carry = w[W-1].
    - asr: {w[W-1], w[W-1:1]}, carry = w[0].
    - lsr: {0, w[W-1:1]}, carry = w[0].
  - Decrement count; when count == 1, go to DONE on the same edge.
- DONE:
  - done = 1 for exactly one cycle.
  - zero is updated from the final out value.
  - Next state is IDLE, or a new operation is started if start=1 (back-to-back accepted).
- Latency: done is high k+1 cycles after the accepting edge for amount k (k=0: 1 cycle).
- start is ignored while in SHIFT; captured operands are unaffected by input changes after acceptance.
- Amounts >= WIDTH are iterated literally, with no truncation:
  - Rotates wrap (effective amount mod WIDTH).
  - shl/lsr reach 0.
  - asr saturates to all sign bits.
- out, carry, zero and err hold their values from completion until the next accepted start.
- busy = (state == SHIFT). out updates during SHIFT; it is valid only when done=1.
- flush=1 in any state: next state IDLE, no done pulse, outputs hold; flush has priority over start.
- The sh_type and captured type are held in a register so that the next start can change sh_type freely.

Decomposition:
- Shared package holds:
  - sh_type localparams SH_ROTL=0, SH_ROTR=1, SH_SHL=2, SH_ASR=3, SH_LSR=4.
  - FSM state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step, a combinational 1-bit operation (WIDTH param; ins w, type; outs w_next, bit_out) instanced once in the FSM datapath.

Test Plan:
- Rotl 0x81 by 1 -> out 0x03, carry 1, zero 0; done 2 cycles after the start edge.
- Asr 0x90 by 3 -> out 0xF2, carry 0; busy high 3 cycles, done on cycle 4.
- Lsr 0x01 by 1 -> out 0x00, carry 1, zero 1. Then, in the DONE cycle, start shl 0x01 by 7 -> out 0x80, carry 0; back-to-back accepted with no IDLE gap.
- Shl 0xFF by 12 -> out 0x00, carry 0, done after 13 cycles. Rotr 0xA5 by 0 -> out 0xA5, carry 0, done 1 cycle later. Rotl 0x12 by 9 -> out 0x24.
- sh_type 6, data 0x3C -> err 1, out 0x3C, done 1 cycle later. A start pulse during SHIFT of a prior op (rotr 0x01 by 5) is ignored -> result 0x08.
- Start asr 0x80 by 10, assert rst_n=0 at cycle 4 -> all outputs 0 immediately, no done. Repeat with flush at cycle 4 -> IDLE, no done, out holds its last value.
